// File: rtl/bcd_addsub_seq.sv
`default_nettype none
// ============================================================================
// Module   : bcd_addsub_seq
// Brief    : Digit-serial packed-BCD adder/subtractor (LSD first) with
//            sign-magnitude recomplement and invalid-digit detection.
//            Optional multiplexed 7-segment scan: define BCD_SEG_SCAN_EN.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_addsub_seq #(
    parameter int DIGITS = 4
`ifdef BCD_SEG_SCAN_EN
    ,
    parameter int SCAN_DIV = 1000
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                mode,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] result,
    output logic                carry_sign,
    output logic                error
`ifdef BCD_SEG_SCAN_EN
    ,
    output logic [6:0]          seg_out,
    output logic [DIGITS-1:0]   an
`endif
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] c_last_idx = IW'(DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              r_state;
    logic [4*DIGITS-1:0] r_a;
    logic [4*DIGITS-1:0] r_b;
    logic [4*DIGITS-1:0] r_result;
    logic                r_mode;
    logic                r_c;
    logic                r_busy;
    logic                r_done;
    logic                r_carry_sign;
    logic                r_error;
    logic [IW-1:0]       r_idx;

    logic [IW+1:0]       w_base;
    logic                w_invalid;
    logic [3:0]          w_x;
    logic [3:0]          w_y;
    logic [4:0]          w_sum;
    logic                w_cout;
    logic [3:0]          w_dig;

    assign w_base = {r_idx, 2'b00};

    always_comb begin
        w_invalid = 1'b0;
        for (int j = 0; j < DIGITS; j++) begin
            if (a[4*j +: 4] > 4'd9 || b[4*j +: 4] > 4'd9) begin
                w_invalid = 1'b1;
            end
        end
    end

    // One shared digit adder: RUN adds a_i + (b_i or 9-b_i), FIX adds 9-r_i.
    always_comb begin
        w_x = r_a[w_base +: 4];
        w_y = r_mode ? (4'd9 - r_b[w_base +: 4]) : r_b[w_base +: 4];
        if (r_state == S_FIX) begin
            w_x = 4'd9 - r_result[w_base +: 4];
            w_y = 4'd0;
        end
        w_sum  = {1'b0, w_x} + {1'b0, w_y} + {4'd0, r_c};
        w_cout = (w_sum > 5'd9);
        w_dig  = w_cout ? 4'(w_sum + 5'd6) : w_sum[3:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_a          <= '0;
            r_b          <= '0;
            r_result     <= '0;
            r_mode       <= 1'b0;
            r_c          <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_carry_sign <= 1'b0;
            r_error      <= 1'b0;
            r_idx        <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_state <= S_IDLE;
                    if (start) begin
                        r_a    <= a;
                        r_b    <= b;
                        r_mode <= mode;
                        r_c    <= mode;
                        r_idx  <= '0;
                        if (w_invalid) begin
                            r_result     <= '1;
                            r_error      <= 1'b1;
                            r_carry_sign <= 1'b0;
                            r_done       <= 1'b1;
                            r_busy       <= 1'b0;
                            r_state      <= S_DONE;
                        end else begin
                            r_error <= 1'b0;
                            r_busy  <= 1'b1;
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    r_result[w_base +: 4] <= w_dig;
                    r_c                   <= w_cout;
                    r_idx                 <= r_idx + IW'(1);
                    if (r_idx == c_last_idx) begin
                        if (r_mode && !w_cout) begin
                            // No end-around carry: a < b, recomplement the digits
                            r_carry_sign <= 1'b1;
                            r_idx        <= '0;
                            r_c          <= 1'b1;
                            r_state      <= S_FIX;
                        end else begin
                            r_carry_sign <= r_mode ? 1'b0 : w_cout;
                            r_busy       <= 1'b0;
                            r_done       <= 1'b1;
                            r_state      <= S_DONE;
                        end
                    end
                end
                S_FIX: begin
                    r_result[w_base +: 4] <= w_dig;
                    r_c                   <= w_cout;
                    r_idx                 <= r_idx + IW'(1);
                    if (r_idx == c_last_idx) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign result     = r_result;
    assign carry_sign = r_carry_sign;
    assign error      = r_error;

`ifdef BCD_SEG_SCAN_EN
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] c_pre_last = PW'(SCAN_DIV - 1);

    logic [PW-1:0]       r_pre;
    logic [IW-1:0]       r_ptr;
    logic [4*DIGITS-1:0] r_disp;
    logic [IW+1:0]       w_ptr_base;
    logic [3:0]          w_disp_dig;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre  <= '0;
            r_ptr  <= '0;
            r_disp <= '0;
        end else begin
            if (r_done) begin
                r_disp <= r_result;
            end
            if (r_pre == c_pre_last) begin
                r_pre <= '0;
                r_ptr <= (r_ptr == c_last_idx) ? '0 : r_ptr + IW'(1);
            end else begin
                r_pre <= r_pre + PW'(1);
            end
        end
    end

    assign w_ptr_base = {r_ptr, 2'b00};
    assign w_disp_dig = r_disp[w_ptr_base +: 4];
    assign an         = ~(DIGITS'(1) << r_ptr);

    always_comb begin
        case (w_disp_dig)
            4'd0:    seg_out = 7'b1000000;
            4'd1:    seg_out = 7'b1111001;
            4'd2:    seg_out = 7'b0100100;
            4'd3:    seg_out = 7'b0110000;
            4'd4:    seg_out = 7'b0011001;
            4'd5:    seg_out = 7'b0010010;
            4'd6:    seg_out = 7'b0000010;
            4'd7:    seg_out = 7'b1111000;
            4'd8:    seg_out = 7'b0000000;
            4'd9:    seg_out = 7'b0010000;
            default: seg_out = 7'b1111111;
        endcase
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_bcd_addsub_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_addsub_seq
// Brief    : Directed plus randomized bench for bcd_addsub_seq (DIGITS = 4)
//            against an integer-arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_addsub_seq;

    localparam int DIGITS = 4;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        start = 1'b0;
    logic        mode  = 1'b0;
    logic [15:0] a     = '0;
    logic [15:0] b     = '0;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        carry_sign;
    logic        error;
`ifdef BCD_SEG_SCAN_EN
    logic [6:0]  seg_out;
    logic [3:0]  an;
`endif

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    bcd_addsub_seq #(
        .DIGITS(DIGITS)
`ifdef BCD_SEG_SCAN_EN
        , .SCAN_DIV(4)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .mode(mode),
        .a(a),
        .b(b),
        .busy(busy),
        .done(done),
        .result(result),
        .carry_sign(carry_sign),
        .error(error)
`ifdef BCD_SEG_SCAN_EN
        , .seg_out(seg_out)
        , .an(an)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int bcd2int(input logic [15:0] v);
        int r = 0;
        for (int i = 3; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [15:0] int2bcd(input int n);
        logic [15:0] r;
        int          t = n;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic bit is_bcd(input logic [15:0] v);
        for (int i = 0; i < 4; i++) if (v[4*i +: 4] > 4'd9) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Expected result/sign/error and done latency from plain decimal arithmetic.
    task automatic model(input logic [15:0] av, input logic [15:0] bv, input bit m,
                         output logic [15:0] er, output bit ec, output bit ee, output int lat);
        int ia, ib, s;
        if (!is_bcd(av) || !is_bcd(bv)) begin
            er = 16'hFFFF; ec = 1'b0; ee = 1'b1; lat = 1;
        end else begin
            ia = bcd2int(av);
            ib = bcd2int(bv);
            ee = 1'b0;
            if (!m) begin
                s = ia + ib;
                er = int2bcd(s % 10000); ec = (s >= 10000); lat = DIGITS + 1;
            end else if (ia >= ib) begin
                er = int2bcd(ia - ib); ec = 1'b0; lat = DIGITS + 1;
            end else begin
                er = int2bcd(ib - ia); ec = 1'b1; lat = 2 * DIGITS + 1;
            end
        end
    endtask

    task automatic launch(input logic [15:0] av, input logic [15:0] bv, input bit m);
        @(negedge clk);
        a = av; b = bv; mode = m; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int c0, output int cyc);
        cyc = c0;
        while (done !== 1'b1 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic check_result(input string tag, input int cyc, input logic [15:0] er,
                                input bit ec, input bit ee, input int lat);
        check({tag, "_done"},   done, 1'b1);
        check({tag, "_lat"},    cyc, lat);
        check({tag, "_result"}, result, er);
        check({tag, "_sign"},   carry_sign, ec);
        check({tag, "_error"},  error, ee);
        check({tag, "_busy0"},  busy, 1'b0);
    endtask

    task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv, input bit m);
        logic [15:0] er;
        bit          ec, ee;
        int          lat, cyc;
        model(av, bv, m, er, ec, ee, lat);
        launch(av, bv, m);
        if (lat > 1) check({tag, "_busy1"}, busy, 1'b1);
        wait_done(1, cyc);
        check_result(tag, cyc, er, ec, ee, lat);
    endtask

    initial begin
        logic [15:0] er, av, bv;
        bit          ec, ee, m, saw_done;
        int          lat, cyc;

        // Reset state
        #12;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_result", result, 16'h0000);
        check("rst_sign", carry_sign, 1'b0);
        check("rst_error", error, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Directed arithmetic cases
        run_op("add_457_789", 16'h0457, 16'h0789, 1'b0);
        check("add_457_789_lit", result, 16'h1246);
        run_op("add_carry", 16'h9999, 16'h0001, 1'b0);
        run_op("sub_pos", 16'h0500, 16'h0123, 1'b1);
        run_op("sub_neg", 16'h0123, 16'h0500, 1'b1);
        check("sub_neg_lit", result, 16'h0377);
        run_op("sub_eq", 16'h4321, 16'h4321, 1'b1);
        run_op("invalid", 16'h00A1, 16'h0002, 1'b0);
        run_op("after_inv", 16'h0457, 16'h0789, 1'b0);

        // Start while busy is ignored
        model(16'h0457, 16'h0789, 1'b0, er, ec, ee, lat);
        launch(16'h0457, 16'h0789, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; mode = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(3, cyc);
        check_result("busy_ign", cyc, er, ec, ee, lat);

        // Asynchronous reset mid-RUN aborts without done
        launch(16'h9999, 16'h0001, 1'b0);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_result", result, 16'h0000);
        check("mid_rst_sign", carry_sign, 1'b0);
        check("mid_rst_error", error, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) saw_done = 1'b1;
        end
        check("mid_rst_nodone", saw_done, 1'b0);
        run_op("post_rst", 16'h2468, 16'h1357, 1'b1);

        // Start held high through DONE is accepted there
        model(16'h0123, 16'h0500, 1'b1, er, ec, ee, lat);
        @(negedge clk);
        a = 16'h0123; b = 16'h0500; mode = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        wait_done(1, cyc);
        check_result("held_1", cyc, er, ec, ee, lat);
        model(16'h0457, 16'h0789, 1'b0, er, ec, ee, lat);
        a = 16'h0457; b = 16'h0789; mode = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        check("held_2_busy1", busy, 1'b1);
        wait_done(1, cyc);
        check_result("held_2", cyc, er, ec, ee, lat);

`ifdef BCD_SEG_SCAN_EN
        // Scan: sync to the start of digit 0's slot, then step slot by slot
        begin
            logic [3:0] prev;
            logic [3:0] exp_an;
            prev = an;
            for (int i = 0; i < 40; i++) begin
                @(posedge clk); #1;
                if (an == 4'b1110 && prev != 4'b1110) break;
                prev = an;
            end
            for (int k = 0; k < 5; k++) begin
                exp_an = ~(4'b0001 << (k % 4));
                check("scan_an", an, exp_an);
                check("scan_seg", seg_out, seg_code(er[4*(k%4) +: 4]));
                repeat (4) @(posedge clk);
                #1;
            end
            run_op("scan_inv", 16'hF000, 16'h0000, 1'b0);
            @(posedge clk); #1;
            for (int k = 0; k < 4; k++) begin
                check("scan_blank", seg_out, 7'b1111111);
                repeat (4) @(posedge clk);
                #1;
            end
        end
`endif

        // Randomized operations against the reference model
        for (int n = 0; n < 24; n++) begin
            m  = 1'($urandom_range(0, 1));
            av = int2bcd(int'($urandom_range(0, 9999)));
            bv = int2bcd(int'($urandom_range(0, 9999)));
            if ($urandom_range(0, 7) == 0) av[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
            run_op($sformatf("rnd%0d", n), av, bv, m);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
